paket_unpacker: RTL and testbench
=================================

// Module: paket_unpacker
// PURPOSE
//  Receive end of the sniffer packet stream. Takes four 38-bit packet ports
//  (Paket_port1..4) and buffers each in its own FIFO. Round-robin arbitrates
//  them onto one data/cmd/tag output stream with a valid/ready handshake.
//  Sits downstream of sniffer and feeds the command decoder / scoreboard.
//  Packet format: [37:36]=tag, [35:32]=cmd, [31:0]=data. cmd==4'h0 means idle.
// PARAMETERS
//  FIFO_DEPTH  4  entries per port FIFO; power of 2, >=2
// PORTS
//  clk          in   1   single clock, all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  Paket_port1  in   38  packet, port 0 (same for 2..4 -> ports 1..3)
//  Paket_port2  in   38  packet, port 1
//  Paket_port3  in   38  packet, port 2
//  Paket_port4  in   38  packet, port 3
//  pkt_valid    in   4   bit i: Paket_port(i+1) valid
//  pkt_ready    out  4   bit i: port i can accept
//  data_out     out  32  unpacked data
//  cmd_out      out  4   unpacked cmd
//  tag_out      out  2   unpacked tag
//  port_out     out  2   source port index 0..3
//  out_valid    out  1   output holds a packet
//  out_ready    in   1   consumer accepts output
//  drop_cnt     out  16  idle-packet drop count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FIFOs empty, pointers 0, out_valid=0, data/cmd/tag/port_out=0,
//   rr_last=3 (port 0 highest priority), drop_cnt=0, pkt_ready=0 while rst=1.
//  Reset mid-operation discards all buffered and held packets; no partial output.
//  Input handshake per port: push when pkt_valid[i] && pkt_ready[i].
//   pkt_ready[i] = !rst_q && !full[i]; a pop in the same cycle does NOT free a slot.
//   Pushed packet with cmd==0 is consumed but not written (idle discard).
//  FIFO: FIFO_DEPTH entries, wr/rd pointers wrap modulo depth, extra-bit full/empty.
//  Output stage FSM: EMPTY (out_valid=0) / HOLD (out_valid=1).
//   EMPTY: if any FIFO non-empty -> pop granted FIFO, load outputs, go HOLD.
//   HOLD: fields stable while out_ready=0. On out_ready=1: if any FIFO non-empty
//    reload from next grant same edge (back-to-back, 1 pkt/cycle), else EMPTY.
//  Arbiter: round-robin; search order rr_last+1, +2, +3, +4 (mod 4);
//   rr_last <= granted port on each pop.
//  Latency: push at edge E -> out_valid high after edge E+1 (given empty path).
//  Total storage per port = FIFO_DEPTH + 1 while held in output stage.
//  Per-port ordering preserved; no reordering within a port.
// CONFIGURATION
//  `UNPACK_STATS_EN defined: drop_cnt increments by number of idle (cmd==0)
//   packets pushed this cycle (0..4), saturates at 16'hFFFF, clears on rst.
//  Not defined: drop_cnt tied to 16'h0000, no counter logic.
// TESTING
//  1 Reset: rst=1 2 cycles -> out_valid=0, outputs 0, pkt_ready=4'h0; after -> 4'hF.
//  2 Single: Paket_port1={2'd0,4'd1,32'd25}, pkt_valid=4'b0001 1 cycle,
//    out_ready=1 -> out_valid 1 cycle later for 1 cycle: data 25, cmd 1, tag 0, port 0.
//  3 All ports same cycle: (tag,cmd)=(0,1),(2,2),(3,6),(1,5), data 25 each ->
//    4 consecutive outputs port 0,1,2,3 with those cmd/tag, then out_valid=0.
//  4 Backpressure: out_ready=0, 6 pushes on port 2 (data 1..6) -> pkt_ready[2]=0
//    after 5th push; raise out_ready -> data 1..5 out in order, then 6.
//  5 Idle: Paket_port4 cmd=0 pushed -> pkt_ready[3]=1, no output; with
//    `UNPACK_STATS_EN drop_cnt=1, without drop_cnt=0.
//  6 Reset mid-op: 3 packets buffered, rst 1 cycle -> out_valid=0 and no
//    stale packet emerges after reset release.

Source files
------------

// File: rtl/paket_unpacker.sv
// paket_unpacker: receive side of the sniffer packet stream.
// Four 38-bit packet ports ({tag[1:0], cmd[3:0], data[31:0]}) are each buffered
// in a private FIFO. A round-robin arbiter drains the FIFOs into a single
// registered output stage with a valid/ready handshake. Packets with cmd==0
// are idle fillers: they are accepted but never stored.
// Optional feature: define UNPACK_STATS_EN to count accepted idle packets on
// drop_cnt (saturating). Without it drop_cnt is a constant zero.
module paket_unpacker #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [37:0] Paket_port1,
  input  logic [37:0] Paket_port2,
  input  logic [37:0] Paket_port3,
  input  logic [37:0] Paket_port4,
  input  logic [3:0]  pkt_valid,
  output logic [3:0]  pkt_ready,
  output logic [31:0] data_out,
  output logic [3:0]  cmd_out,
  output logic [1:0]  tag_out,
  output logic [1:0]  port_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] drop_cnt
);

  // Pointer index width; one extra MSB distinguishes full from empty.
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  logic [3:0][37:0] pkt_in;
  logic [3:0][37:0] head;
  logic [3:0]       fifo_full;
  logic [3:0]       fifo_empty;
  logic [3:0]       push;
  logic [3:0]       wr_en;
  logic [3:0]       pop;

  logic             rst_q_reg;
  state_t           state_reg;
  state_t           state_next;
  logic             load;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic [1:0]       rr_last_reg;

  assign pkt_in[0] = Paket_port1;
  assign pkt_in[1] = Paket_port2;
  assign pkt_in[2] = Paket_port3;
  assign pkt_in[3] = Paket_port4;

  // Delayed copy of reset keeps the inputs closed for one cycle after release
  always_ff @(posedge clk) begin
    rst_q_reg <= rst;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      logic [37:0] mem [FIFO_DEPTH];
      logic [AW:0] wr_ptr_reg;
      logic [AW:0] rd_ptr_reg;

      assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
      assign fifo_full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                              (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

      // Readiness depends only on registered occupancy, so a pop in the
      // same cycle never opens a slot early (no ready->valid comb path).
      assign pkt_ready[gi] = !rst && !rst_q_reg && !fifo_full[gi];
      assign push[gi]      = pkt_valid[gi] && pkt_ready[gi];
      assign wr_en[gi]     = push[gi] && (pkt_in[gi][35:32] != 4'h0);
      assign pop[gi]       = load && (grant_idx == 2'(gi));
      assign head[gi]      = mem[rd_ptr_reg[AW-1:0]];

      // Packet storage write; contents need no reset, pointers define validity
      always_ff @(posedge clk) begin
        if (wr_en[gi]) begin
          mem[wr_ptr_reg[AW-1:0]] <= pkt_in[gi];
        end
      end

      // Read/write pointers wrap naturally modulo 2*depth
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (wr_en[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
          end
        end
      end
    end
  endgenerate

  // Round-robin grant: first non-empty FIFO after the last granted port
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_last_reg + k[1:0];
      if (!grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Output stage next-state: load whenever the stage is free or being drained
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (grant_valid) begin
          load       = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (grant_valid) begin
            load = 1'b1;
          end else begin
            state_next = ST_EMPTY;
          end
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // Output stage state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output fields and arbiter history; fields only change on a load
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out    <= '0;
      cmd_out     <= '0;
      tag_out     <= '0;
      port_out    <= '0;
      rr_last_reg <= 2'd3;
    end else if (load) begin
      data_out    <= head[grant_idx][31:0];
      cmd_out     <= head[grant_idx][35:32];
      tag_out     <= head[grant_idx][37:36];
      port_out    <= grant_idx;
      rr_last_reg <= grant_idx;
    end
  end

  assign out_valid = (state_reg == ST_HOLD);

`ifdef UNPACK_STATS_EN
  logic [15:0] drop_cnt_reg;
  logic [2:0]  idle_sum;
  logic [16:0] drop_sum;

  // Number of idle packets accepted this cycle (0..4)
  always_comb begin
    idle_sum = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (push[k] && (pkt_in[k][35:32] == 4'h0)) begin
        idle_sum = idle_sum + 3'd1;
      end
    end
  end

  assign drop_sum = {1'b0, drop_cnt_reg} + {14'd0, idle_sum};

  // Saturating idle-drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (drop_sum[16]) begin
      drop_cnt_reg <= 16'hFFFF;
    end else begin
      drop_cnt_reg <= drop_sum[15:0];
    end
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_paket_unpacker.sv
// Bench for paket_unpacker: directed scenarios followed by random traffic.
// A queue-based reference model predicts every transfer; a negedge monitor
// checks the DUT outputs against the scoreboard queue.
module tb_paket_unpacker;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [37:0] pin [4];
  logic [3:0]  pkt_valid;
  logic [3:0]  pkt_ready;
  logic [31:0] data_out;
  logic [3:0]  cmd_out;
  logic [1:0]  tag_out;
  logic [1:0]  port_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] drop_cnt;

  paket_unpacker #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .Paket_port1 (pin[0]),
    .Paket_port2 (pin[1]),
    .Paket_port3 (pin[2]),
    .Paket_port4 (pin[3]),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .data_out    (data_out),
    .cmd_out     (cmd_out),
    .tag_out     (tag_out),
    .port_out    (port_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [37:0] pkt;
    int          port;
  } exp_t;

  logic [37:0] fq [4][$];   // packets waiting in each port buffer
  exp_t        exp_q[$];    // packets presented or about to be presented
  bit          m_held = 1'b0;
  bit          m_rstq = 1'b1;
  int          m_rr   = 3;
  int          m_drop = 0;

  always @(posedge clk) begin : model
    logic [3:0] rdy;
    bit         found;
    int         g;
    int         c;
    exp_t       e;
    if (rst) begin
      for (int i = 0; i < 4; i++) fq[i].delete();
      exp_q.delete();
      m_held = 1'b0;
      m_rr   = 3;
      m_drop = 0;
      m_rstq = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) rdy[i] = !m_rstq && (fq[i].size() < DEPTH);
      if (!m_held || out_ready) begin
        found = 1'b0;
        g = 0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_rr + k) % 4;
          if (!found && fq[c].size() > 0) begin
            found = 1'b1;
            g = c;
          end
        end
        if (found) begin
          e.pkt  = fq[g].pop_front();
          e.port = g;
          exp_q.push_back(e);
          m_held = 1'b1;
          m_rr   = g;
        end else begin
          m_held = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (pkt_valid[i] && rdy[i]) begin
          if (pin[i][35:32] != 4'h0) fq[i].push_back(pin[i]);
          else if (m_drop < 65535) m_drop++;
        end
      end
      m_rstq = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [3:0] exp_rdy;
    exp_t       e;
    for (int i = 0; i < 4; i++) exp_rdy[i] = !rst && !m_rstq && (fq[i].size() < DEPTH);
    chk("pkt_ready", pkt_ready, exp_rdy);
    chk("out_valid", out_valid, m_held);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        if (n_fail <= 40) $display("FAIL unexpected_output: got port %0d data %0h expected no packet", port_out, data_out);
      end else begin
        e = exp_q[0];
        chk("data_out", data_out, e.pkt[31:0]);
        chk("cmd_out", cmd_out, e.pkt[35:32]);
        chk("tag_out", tag_out, e.pkt[37:36]);
        chk("port_out", port_out, e.port);
        if (out_ready) begin
          $display("xfer port=%0d tag=%0d cmd=%0h data=%08h", port_out, tag_out, cmd_out, data_out);
          void'(exp_q.pop_front());
        end
      end
    end
`ifdef UNPACK_STATS_EN
    chk("drop_cnt", drop_cnt, m_drop);
`else
    chk("drop_cnt", drop_cnt, 16'h0000);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pkt_valid = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int to;
    int hi;
    rst = 1'b1;
    pkt_valid = 4'h0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pin[i] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_cmd", cmd_out, 4'd0);
    chk("rst_tag", tag_out, 2'd0);
    chk("rst_port", port_out, 2'd0);
    chk("rst_ready", pkt_ready, 4'h0);
    chk("rst_drop", drop_cnt, 16'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", pkt_ready, 4'hF);

    // Single packet latency
    out_ready = 1'b1;
    pin[0] = {2'd0, 4'd1, 32'd25};
    pkt_valid = 4'b0001;
    tick();
    pkt_valid = 4'h0;
    chk("single_not_yet", out_valid, 1'b0);
    tick();
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", data_out, 32'd25);
    chk("single_cmd", cmd_out, 4'd1);
    chk("single_tag", tag_out, 2'd0);
    chk("single_port", port_out, 2'd0);
    tick();
    chk("single_done", out_valid, 1'b0);

    // All ports in one cycle, round-robin from port 0
    do_reset();
    out_ready = 1'b1;
    pin[0] = {2'd0, 4'd1, 32'd25};
    pin[1] = {2'd2, 4'd2, 32'd25};
    pin[2] = {2'd3, 4'd6, 32'd25};
    pin[3] = {2'd1, 4'd5, 32'd25};
    pkt_valid = 4'hF;
    tick();
    pkt_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_valid", out_valid, 1'b1);
      chk("rr_port", port_out, k);
    end
    tick();
    chk("rr_done", out_valid, 1'b0);

    // Backpressure on port 2
    out_ready = 1'b0;
    for (int d = 1; d <= 6; d++) begin
      pin[2] = {2'd1, 4'd3, 32'(d)};
      pkt_valid = 4'b0100;
      if (d == 6) begin
        tick();
        tick();
        chk("full_blocks", pkt_ready[2], 1'b0);
        out_ready = 1'b1;
      end
      to = 0;
      while (!pkt_ready[2] && to < 20) begin
        tick();
        to++;
      end
      if (to >= 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL push_timeout: pkt_ready[2] stayed 0 for %0d cycles, required 1", to);
      end
      tick();
      if (d == 5) chk("full_after_5", pkt_ready[2], 1'b0);
    end
    pkt_valid = 4'h0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("bp_drained", out_valid, 1'b0);

    // Idle packet is consumed, not forwarded
    do_reset();
    out_ready = 1'b1;
    pin[3] = {2'd2, 4'd0, 32'hDEAD_BEEF};
    pkt_valid = 4'b1000;
    chk("idle_ready", pkt_ready[3], 1'b1);
    tick();
    pkt_valid = 4'h0;
    tick();
    tick();
    chk("idle_no_output", out_valid, 1'b0);
`ifdef UNPACK_STATS_EN
    chk("idle_drop", drop_cnt, 16'd1);
`else
    chk("idle_drop", drop_cnt, 16'd0);
`endif

    // Reset while packets are buffered
    do_reset();
    out_ready = 1'b0;
    pin[0] = {2'd1, 4'd7, 32'h1111};
    pin[1] = {2'd2, 4'd8, 32'h2222};
    pin[2] = {2'd3, 4'd9, 32'h3333};
    pkt_valid = 4'b0111;
    tick();
    pkt_valid = 4'h0;
    tick();
    chk("midrst_held", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_cleared", out_valid, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("midrst_no_stale", out_valid, 1'b0);
    end

    // Random traffic with varying backpressure and occasional resets
    for (int c = 0; c < 2500; c++) begin
      hi = ((c / 250) % 2 == 0) ? 9 : 3;
      for (int i = 0; i < 4; i++) begin
        pin[i][37:36] = 2'($urandom);
        pin[i][35:32] = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        pin[i][31:0]  = $urandom;
      end
      pkt_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < hi);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    pkt_valid = 4'h0;
    out_ready = 1'b1;
    repeat (30) tick();
    chk("final_idle", out_valid, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
